// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control types and stall-length constants.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        HAZ      = 2'd1,
        MDU_WAIT = 2'd2
    } state_e;

    localparam logic [1:0] STALL_EXE_CYC = 2'd3;
    localparam logic [1:0] STALL_MEM_CYC = 2'd2;

    // Total hold cycles for a decode hazard, including the detection cycle.
    function automatic logic [1:0] stall_len(input logic conflict_exe);
        return conflict_exe ? STALL_EXE_CYC : STALL_MEM_CYC;
    endfunction

endpackage

// File: rtl/pipe_perf_cnt.sv
// 32-bit saturating event counter for stall-cycle accounting.
// Latency: count visible one cycle after the counted event.
// Backpressure: none; sticks at all-ones once saturated.
module pipe_perf_cnt (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc_i,
    output logic [31:0] cnt_o
);

    logic [31:0] cnt_q;
    logic [31:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != 32'hFFFF_FFFF)) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 32'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush controller (hazard + MDU wait); PIPE_STALL_PERF_CNT_EN adds stall_cycles.
// Latency: holds/bubble/flush combinational in the request cycle; state and counter registered.
// Backpressure: holds PC and IF/ID until the hazard count or MDU completion releases them.
module pipe_stall_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_req,
    input  logic [1:0]  stall_code,
    input  logic        flush_req,
    input  logic        mdu_start,
    input  logic        mdu_done,
    output logic [1:0]  stall_count,
    output logic        pc_hold,
    output logic        ifid_hold,
    output logic        idex_bubble,
    output logic        exmem_hold,
    output logic        ifid_flush,
    output logic        busy
`ifdef PIPE_STALL_PERF_CNT_EN
    ,
    output logic [31:0] stall_cycles
`endif
);

    state_e     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic       pc_hold_c, ifid_hold_c, idex_bubble_c, exmem_hold_c;

    // Only the EXE/MEM bit selects the length; stall_req alone triggers the hazard.
    logic unused_stall_bit;
    assign unused_stall_bit = stall_code[1];

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        pc_hold_c     = 1'b0;
        ifid_hold_c   = 1'b0;
        idex_bubble_c = 1'b0;
        exmem_hold_c  = 1'b0;
        unique case (state_q)
            RUN: begin
                if (mdu_start) begin
                    pc_hold_c    = 1'b1;
                    ifid_hold_c  = 1'b1;
                    exmem_hold_c = 1'b1;
                    state_d      = MDU_WAIT;
                end else if (stall_req) begin
                    pc_hold_c     = 1'b1;
                    ifid_hold_c   = 1'b1;
                    idex_bubble_c = 1'b1;
                    cnt_d         = stall_len(stall_code[0]) - 2'd1;
                    state_d       = HAZ;
                end
            end
            HAZ: begin
                pc_hold_c     = 1'b1;
                ifid_hold_c   = 1'b1;
                idex_bubble_c = 1'b1;
                if (cnt_q <= 2'd1) begin
                    cnt_d   = 2'd0;
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            MDU_WAIT: begin
                if (mdu_done) begin
                    state_d = RUN;
                end else begin
                    pc_hold_c    = 1'b1;
                    ifid_hold_c  = 1'b1;
                    exmem_hold_c = 1'b1;
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Gate with rst_n so requests arriving during reset cannot leak through.
    assign pc_hold     = pc_hold_c & rst_n;
    assign ifid_hold   = ifid_hold_c & rst_n;
    assign idex_bubble = idex_bubble_c & rst_n;
    assign exmem_hold  = exmem_hold_c & rst_n;
    assign ifid_flush  = flush_req & ~pc_hold & rst_n;
    assign busy        = (state_q != RUN) & rst_n;
    assign stall_count = cnt_q;

`ifdef PIPE_STALL_PERF_CNT_EN
    pipe_perf_cnt u_perf_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (pc_hold),
        .cnt_o (stall_cycles)
    );
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed-vector bench for pipe_stall_ctrl; outputs packed as
// {pc_hold, ifid_hold, idex_bubble, exmem_hold, ifid_flush, busy}.
module tb_pipe_stall_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_req, flush_req, mdu_start, mdu_done;
    logic [1:0]  stall_code;
    logic [1:0]  stall_count;
    logic        pc_hold, ifid_hold, idex_bubble, exmem_hold, ifid_flush, busy;
`ifdef PIPE_STALL_PERF_CNT_EN
    logic [31:0] stall_cycles;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_stall_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall_req   (stall_req),
        .stall_code  (stall_code),
        .flush_req   (flush_req),
        .mdu_start   (mdu_start),
        .mdu_done    (mdu_done),
        .stall_count (stall_count),
        .pc_hold     (pc_hold),
        .ifid_hold   (ifid_hold),
        .idex_bubble (idex_bubble),
        .exmem_hold  (exmem_hold),
        .ifid_flush  (ifid_flush),
        .busy        (busy)
`ifdef PIPE_STALL_PERF_CNT_EN
        ,
        .stall_cycles(stall_cycles)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Checks outputs mid-cycle, then advances to just after the next rising edge.
    task automatic step(input string tag, input logic [5:0] exp_o, input logic [1:0] exp_cnt);
        #3;
        chk({tag, "_o"}, {26'd0, pc_hold, ifid_hold, idex_bubble, exmem_hold, ifid_flush, busy},
            {26'd0, exp_o});
        chk({tag, "_cnt"}, {30'd0, stall_count}, {30'd0, exp_cnt});
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic sr, input logic [1:0] sc, input logic fl,
                         input logic ms, input logic md);
        stall_req  = sr;
        stall_code = sc;
        flush_req  = fl;
        mdu_start  = ms;
        mdu_done   = md;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b1, 2'b11, 1'b1, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        step("rst_gate", 6'b000000, 2'd0);
        drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        step("idle", 6'b000000, 2'd0);

        // EXE conflict: 3 hold cycles, count 0,2,1; mdu_start ignored in HAZ
        drive(1'b1, 2'b11, 1'b0, 1'b0, 1'b0);
        step("exe_c1", 6'b111000, 2'd0);
        drive(1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        step("exe_c2", 6'b111001, 2'd2);
        drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        step("exe_c3", 6'b111001, 2'd1);
        step("exe_c4", 6'b000000, 2'd0);

        // MEM conflict with stall_req held through HAZ
        drive(1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
        step("mem_c1", 6'b111000, 2'd0);
        step("mem_c2", 6'b111001, 2'd1);
        drive(1'b0, 2'b10, 1'b0, 1'b0, 1'b0);
        step("mem_c3", 6'b000000, 2'd0);

        // MDU: start, six wait cycles, done on cycle +7
        drive(1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        step("mdu_start", 6'b110100, 2'd0);
        drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 6; i++) begin
            stall_req = (i == 3);
            stall_code = (i == 3) ? 2'b11 : 2'b00;
            step($sformatf("mdu_wait%0d", i), 6'b110101, 2'd0);
        end
        drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
        step("mdu_done", 6'b000001, 2'd0);
        drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        step("mdu_after", 6'b000000, 2'd0);

        // mdu_start wins over stall_req
        drive(1'b1, 2'b11, 1'b0, 1'b1, 1'b0);
        step("prio_c1", 6'b110100, 2'd0);
        drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        step("prio_c2", 6'b110101, 2'd0);
        drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
        step("prio_done", 6'b000001, 2'd0);

        // mdu_done in RUN does nothing
        step("done_run", 6'b000000, 2'd0);

        // flush suppressed while PC held
        drive(1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
        step("flush_run", 6'b000010, 2'd0);
        drive(1'b1, 2'b10, 1'b1, 1'b0, 1'b0);
        step("flush_det", 6'b111000, 2'd0);
        drive(1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
        step("flush_haz", 6'b111001, 2'd1);
        step("flush_back", 6'b000010, 2'd0);

        // async reset mid-HAZ with counter=1
        drive(1'b1, 2'b11, 1'b0, 1'b0, 1'b0);
        step("rh_c1", 6'b111000, 2'd0);
        drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        step("rh_c2", 6'b111001, 2'd2);
        #1;
        chk("rh_pre_cnt", {30'd0, stall_count}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rh_o", {26'd0, pc_hold, ifid_hold, idex_bubble, exmem_hold, ifid_flush, busy}, 32'd0);
        chk("rh_cnt", {30'd0, stall_count}, 32'd0);
`ifdef PIPE_STALL_PERF_CNT_EN
        chk("rh_perf", stall_cycles, 32'd0);
`endif
        #1;
        rst_n = 1'b1;
        drive(1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
        #1;
        chk("rel_o", {26'd0, pc_hold, ifid_hold, idex_bubble, exmem_hold, ifid_flush, busy},
            {26'd0, 6'b111000});
        @(posedge clk);
        #1;
        drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        step("rel_c2", 6'b111001, 2'd1);
        step("rel_c3", 6'b000000, 2'd0);
`ifdef PIPE_STALL_PERF_CNT_EN
        chk("perf_cnt", stall_cycles, 32'd2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_stall_ctrl.md
PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

Interface
REQ-001 clk  input  1  pipeline clock; all state updates on rising edge.
REQ-002 rst_n  input  1  reset, asynchronous, active-low.
REQ-003 stall_req  input  1  decode-stage hazard stall request; combinational from the control unit.
REQ-004 stall_code  input  2  decode-stage stall code; bit1 = stall, bit0 = conflict in EXE (else MEM).
REQ-005 flush_req  input  1  decode-stage redirect (taken branch, jump, eret, exception).
REQ-006 mdu_start  input  1  one-cycle pulse: multiply/divide unit began a multi-cycle operation in EXE.
REQ-007 mdu_done  input  1  multiply/divide unit result valid this cycle.
REQ-008 stall_count  output  2  remaining hazard-stall cycles, fed back to the control unit as stall_count_in.
REQ-009 pc_hold  output  1  freeze PC.
REQ-010 ifid_hold  output  1  freeze IF/ID register.
REQ-011 idex_bubble  output  1  load NOP into ID/EX register.
REQ-012 exmem_hold  output  1  freeze ID/EX and EX/MEM registers.
REQ-013 ifid_flush  output  1  replace IF/ID contents with NOP.
REQ-014 busy  output  1  state is not RUN.

Function
REQ-015 FSM states: RUN, HAZ, MDU_WAIT; state and 2-bit counter are registered, all other outputs combinational.
REQ-016 Stall length N: N=3 when stall_code[0]=1, else N=2; stall_code ignored when stall_req=0.
REQ-017 RUN, mdu_start=1: pc_hold=ifid_hold=exmem_hold=1 this cycle; next state MDU_WAIT; counter unchanged (0).
REQ-018 RUN, stall_req=1, mdu_start=0: pc_hold=ifid_hold=idex_bubble=1 this cycle; counter<=N-1; next state HAZ.
REQ-019 mdu_start has priority over stall_req in the same cycle; stall_req is not latched.
REQ-020 HAZ: pc_hold=ifid_hold=idex_bubble=1; counter decrements each cycle; when counter=1, next state RUN and counter<=0.
REQ-021 Total hold cycles per hazard = N, including the detection cycle.
REQ-022 HAZ ignores stall_req, stall_code and mdu_start.
REQ-023 MDU_WAIT, mdu_done=0: pc_hold=ifid_hold=exmem_hold=1.
REQ-024 MDU_WAIT, mdu_done=1: all holds are 0 this cycle; next state RUN.
REQ-025 MDU_WAIT ignores stall_req; the control unit re-evaluates the hazard in RUN.
REQ-026 ifid_flush = flush_req AND NOT pc_hold; a flush is never issued while the redirecting instruction is held.
REQ-027 stall_count = counter register; it is 0 in RUN and in MDU_WAIT.
REQ-028 busy = 1 in HAZ and MDU_WAIT.
REQ-029 mdu_done in RUN or HAZ has no effect.

Reset
REQ-030 rst_n low sets state=RUN and counter=0 immediately, including mid-HAZ or mid-MDU_WAIT.
REQ-031 All holds, bubble, flush and busy are 0 during reset.
REQ-032 The first edge after rst_n rises evaluates inputs normally.

Configuration
REQ-033 Macro PIPE_STALL_PERF_CNT_EN defined: adds output stall_cycles [31:0].
REQ-034 With PIPE_STALL_PERF_CNT_EN, stall_cycles increments on every cycle with pc_hold=1, saturates at 32'hFFFFFFFF, and resets to 0.
REQ-035 PIPE_STALL_PERF_CNT_EN undefined: the port and counter are absent; all other behaviour is identical.

Structure
REQ-036 Shared package pipe_ctrl_pkg holds the state enum (RUN, HAZ, MDU_WAIT) and the constants STALL_EXE_CYC=3 and STALL_MEM_CYC=2.
REQ-037 One sub-module, pipe_perf_cnt (32-bit saturating counter), is instantiated only under PIPE_STALL_PERF_CNT_EN.

Verification
REQ-038 stall_req=1, stall_code=2'b11 for 1 cycle -> pc_hold high 3 cycles; stall_count reads 0,2,1 on those cycles; RUN on cycle 4.
REQ-039 stall_req=1, stall_code=2'b10 -> hold 2 cycles; stall_count reads 0,1; stall_req held high during HAZ adds no extra cycles.
REQ-040 mdu_start pulse, mdu_done at cycle +7 -> exmem_hold high for 7 cycles, low on the done cycle, busy low the next cycle.
REQ-041 mdu_start and stall_req same cycle -> MDU_WAIT entered, idex_bubble=0, stall_count=0.
REQ-042 flush_req during HAZ -> ifid_flush=0; flush_req in RUN without stall -> ifid_flush=1 the same cycle.
REQ-043 rst_n low mid-HAZ with counter=1 -> state RUN and all outputs 0 asynchronously; with the macro, stall_cycles reads 0.
